i2c_ram_arbiter: RTL and testbench

//  Sole owner of the 256x9 I2C capture RAM (simple_ram, separate rd/wr data, no tristate). Arbitrates
//  two write streams (priv-bus and main-bus sniffers) and one reader (PMIC substitution core)

---
 rtl/i2c_ram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_i2c_ram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_ram_arbiter.sv
// i2c_ram_arbiter: single-port owner of the 256x9 capture RAM for two write streams and one reader.
// Define ARB_DROP_STATS_EN to build the saturating drop_count statistic; otherwise it reads 0.
module i2c_ram_arbiter #(
    parameter int                DATA_W     = 9,
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] PRIV_BASE  = 'h00,
    parameter int                PRIV_DEPTH = 208,
    parameter logic [ADDR_W-1:0] MAIN_BASE  = 'hD0,
    parameter int                MAIN_DEPTH = 48,
    parameter int                STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              priv_ready,
    input  logic [DATA_W-1:0] priv_data,
    input  logic              priv_clr,
    input  logic              main_ready,
    input  logic [DATA_W-1:0] main_data,
    input  logic              main_clr,
    input  logic              rd_req,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_offset,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty,
    output logic [7:0]        priv_len,
    output logic [7:0]        main_len,
    output logic              priv_ovf,
    output logic              main_ovf,
    output logic [15:0]       drop_count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [7:0] PRIV_FULL = 8'(PRIV_DEPTH);
    localparam logic [7:0] MAIN_FULL = 8'(MAIN_DEPTH);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [2:0] {IDLE, WR_PRIV, WR_MAIN, RD_ISSUE, RD_DONE} state_t;
    state_t state, state_n;

    logic              priv_pv, main_pv;
    logic [DATA_W-1:0] priv_pd, main_pd;
    logic              last_priv;
    logic [SW-1:0]     starve;
    logic              rd_bank_q, rd_empty_q;
    logic [ADDR_W-1:0] rd_off_q;
    logic              priv_full, main_full, priv_drop, main_drop;
    logic              priv_pend, main_pend, grant, rd_miss, in_rd;

    assign priv_full = priv_len == PRIV_FULL;
    assign main_full = main_len == MAIN_FULL;
    // a clear empties the bank first, so a coincident word is always accepted
    assign priv_drop = priv_ready & ~priv_clr & (priv_pv | priv_full);
    assign main_drop = main_ready & ~main_clr & (main_pv | main_full);
    // a slot being cleared this cycle must not be scheduled for a write
    assign priv_pend = priv_pv & ~priv_clr;
    assign main_pend = main_pv & ~main_clr;
    assign grant     = (state == IDLE) && (state_n == RD_ISSUE);
    assign rd_miss   = rd_offset >= ADDR_W'(rd_bank ? priv_len : main_len);
    assign in_rd     = (state == RD_ISSUE) || (state == RD_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            priv_pv    <= 1'b0;
            main_pv    <= 1'b0;
            priv_pd    <= '0;
            main_pd    <= '0;
            priv_len   <= '0;
            main_len   <= '0;
            priv_ovf   <= 1'b0;
            main_ovf   <= 1'b0;
            last_priv  <= 1'b1;
            starve     <= '0;
            rd_bank_q  <= 1'b0;
            rd_off_q   <= '0;
            rd_empty_q <= 1'b0;
        end else begin
            state  <= state_n;
            starve <= grant ? '0 : (rd_req && !in_rd && starve != SMAX) ? starve + 1'b1 : starve;
            if (grant) begin
                rd_bank_q  <= rd_bank;
                rd_off_q   <= rd_offset;
                rd_empty_q <= rd_miss;
            end
            if (state == WR_PRIV) last_priv <= 1'b1;
            else if (state == WR_MAIN) last_priv <= 1'b0;
            if (priv_clr) priv_len <= '0;
            else if (state == WR_PRIV && !priv_full) priv_len <= priv_len + 8'd1;
            if (main_clr) main_len <= '0;
            else if (state == WR_MAIN && !main_full) main_len <= main_len + 8'd1;
            priv_ovf <= priv_clr ? 1'b0 : priv_ovf | priv_drop;
            main_ovf <= main_clr ? 1'b0 : main_ovf | main_drop;
            if (priv_ready && !priv_drop) begin
                priv_pv <= 1'b1;
                priv_pd <= priv_data;
            end else if (priv_clr || state == WR_PRIV) begin
                priv_pv <= 1'b0;
            end
            if (main_ready && !main_drop) begin
                main_pv <= 1'b1;
                main_pd <= main_data;
            end else if (main_clr || state == WR_MAIN) begin
                main_pv <= 1'b0;
            end
        end
    end

`ifdef ARB_DROP_STATS_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, drop_count} + 17'(priv_drop) + 17'(main_drop);
    always_ff @(posedge clk) begin
        if (reset) drop_count <= '0;
        else drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`else
    assign drop_count = 16'h0000;
`endif

    always_comb begin
        state_n   = state;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        rd_empty  = 1'b0;
        case (state)
            // starved read first, then round-robin writes (last served loses), then read
            IDLE: state_n = (rd_req && starve == SMAX) ? RD_ISSUE :
                            (priv_pend && (!main_pend || !last_priv)) ? WR_PRIV :
                            main_pend ? WR_MAIN : rd_req ? RD_ISSUE : IDLE;
            WR_PRIV: begin
                ram_we    = 1'b1;
                ram_addr  = PRIV_BASE + ADDR_W'(priv_len);
                ram_wdata = priv_pd;
                state_n   = IDLE;
            end
            WR_MAIN: begin
                ram_we    = 1'b1;
                ram_addr  = MAIN_BASE + ADDR_W'(main_len);
                ram_wdata = main_pd;
                state_n   = IDLE;
            end
            RD_ISSUE: begin
                ram_re   = !rd_empty_q;
                ram_addr = rd_empty_q ? '0 : (rd_bank_q ? PRIV_BASE : MAIN_BASE) + rd_off_q;
                state_n  = RD_DONE;
            end
            RD_DONE: begin
                rd_valid = 1'b1;
                rd_empty = rd_empty_q;
                rd_data  = rd_empty_q ? '0 : ram_rdata;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_ram_arbiter.sv
// tb_i2c_ram_arbiter: randomized scoreboard bench with a bank-queue reference model and RAM model.
module tb_i2c_ram_arbiter;
    localparam logic [7:0] PB = 8'h00;
    localparam logic [7:0] MB = 8'hD0;
    localparam int PD = 208;
    localparam int MD = 48;
    localparam int SM = 4;
    localparam int NFLOOD = 250;

    logic clk = 0;
    logic reset;
    logic priv_ready, priv_clr, main_ready, main_clr, rd_req, rd_bank;
    logic [8:0] priv_data, main_data, rd_data, ram_wdata, ram_rdata;
    logic [7:0] rd_offset, priv_len, main_len, ram_addr;
    logic rd_valid, rd_empty, priv_ovf, main_ovf, ram_we, ram_re;
    logic [15:0] drop_count;

    i2c_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .priv_ready(priv_ready), .priv_data(priv_data), .priv_clr(priv_clr),
        .main_ready(main_ready), .main_data(main_data), .main_clr(main_clr),
        .rd_req(rd_req), .rd_bank(rd_bank), .rd_offset(rd_offset),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_empty(rd_empty),
        .priv_len(priv_len), .main_len(main_len), .priv_ovf(priv_ovf), .main_ovf(main_ovf),
        .drop_count(drop_count), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [8:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [8:0] pbank[$];
    logic [8:0] mbank[$];
    logic [9:0] rq[$];
    logic [16:0] wq[$];
    int drops;
    bit povf, movf, lastpriv, flood;
    int fcnt;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    function automatic int expdrop();
`ifdef ARB_DROP_STATS_EN
        return drops;
`else
        return 0;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        pbank.delete();
        mbank.delete();
        drops = 0;
        povf = 0;
        movf = 0;
        lastpriv = 1;
    endtask

    task automatic offer(bit b, logic [8:0] d);
        if (b) begin
            if (pbank.size() == PD) begin
                povf = 1;
                drops++;
            end else begin
                wq.push_back({PB + 8'(pbank.size()), d});
                pbank.push_back(d);
                lastpriv = 1;
            end
        end else begin
            if (mbank.size() == MD) begin
                movf = 1;
                drops++;
            end else begin
                wq.push_back({MB + 8'(mbank.size()), d});
                mbank.push_back(d);
                lastpriv = 0;
            end
        end
    endtask

    task automatic wr(bit p, logic [8:0] dp, bit cp, bit m, logic [8:0] dm, bit cm);
        priv_ready = p; priv_data = dp; priv_clr = cp;
        main_ready = m; main_data = dm; main_clr = cm;
        cyc();
        priv_ready = 0; priv_clr = 0; main_ready = 0; main_clr = 0;
        if (cp) begin pbank.delete(); povf = 0; end
        if (cm) begin mbank.delete(); movf = 0; end
        if (p && m) begin
            if (lastpriv) begin offer(0, dm); offer(1, dp); end
            else begin offer(1, dp); offer(0, dm); end
        end else if (p) offer(1, dp);
        else if (m) offer(0, dm);
        repeat (6) cyc();
        chk("priv_len", priv_len, pbank.size());
        chk("main_len", main_len, mbank.size());
        chk("priv_ovf", priv_ovf, povf);
        chk("main_ovf", main_ovf, movf);
    endtask

    task automatic rd(bit b, logic [7:0] off, int maxlat);
        int len, n;
        bit e, sawre;
        logic [8:0] d;
        len = b ? pbank.size() : mbank.size();
        e = int'(off) >= len;
        d = e ? 9'h000 : (b ? pbank[off] : mbank[off]);
        if (flood) begin e = 0; d = 9'h001; end
        rq.push_back({e, d});
        rd_req = 1; rd_bank = b; rd_offset = off;
        n = 0; sawre = 0;
        do begin
            cyc();
            n++;
            if (ram_re) sawre = 1;
        end while (!rd_valid && n < 30);
        rd_req = 0;
        if (maxlat == 2) chk("rd_latency", n, 2);
        else chk("rd_latency_bound", 32'(n <= maxlat), 1);
        if (!flood) chk("rd_ram_re", sawre, !e);
        cyc();
    endtask

    task automatic monitor();
        logic [9:0] r;
        logic [16:0] w;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rd_valid) begin
                    chk("rd_expected", 32'(rq.size() > 0), 1);
                    if (rq.size() > 0) begin
                        r = rq.pop_front();
                        chk("rd_data", rd_data, r[8:0]);
                        chk("rd_empty", rd_empty, r[9]);
                    end
                end
                if (ram_we) begin
                    if (flood) begin
                        chk("flood_addr", ram_addr, MB + fcnt);
                        if (fcnt == 0) chk("flood_first", ram_wdata, 9'h001);
                        fcnt++;
                    end else begin
                        chk("wr_expected", 32'(wq.size() > 0), 1);
                        if (wq.size() > 0) begin
                            w = wq.pop_front();
                            chk("wr_addr", ram_addr, w[16:9]);
                            chk("wr_data", ram_wdata, w[8:0]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int op, len;
        bit b;
        reset = 1;
        priv_ready = 0; priv_data = 0; priv_clr = 0;
        main_ready = 0; main_data = 0; main_clr = 0;
        rd_req = 0; rd_bank = 0; rd_offset = 0;
        flood = 0; fcnt = 0;
        model_reset();
        fork monitor(); join_none
        repeat (3) cyc();
        reset = 0;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_priv_len", priv_len, 0);
        chk("rst_main_len", main_len, 0);
        chk("rst_drop", drop_count, 0);

        wr(1, 9'h0A1, 0, 0, 0, 0);
        wr(1, 9'h0A2, 0, 0, 0, 0);
        wr(1, 9'h0A3, 0, 0, 0, 0);
        wr(1, 9'h0B1, 0, 1, 9'h1C1, 0);
        rd(1, 8'd1, 2);
        rd(1, 8'd5, 2);

        wr(0, 0, 0, 0, 0, 1);
        repeat (50) wr(0, 0, 0, 1, 9'($urandom), 0);
        rd(0, 8'd47, 2);
        rd(0, 8'd48, 2);
        repeat (206) wr(1, 9'($urandom), 0, 0, 0, 0);
        rd(1, 8'd207, 2);
        rd(1, 8'd208, 2);
        chk("fill_drop", drop_count, expdrop());
        wr(0, 0, 1, 0, 0, 1);

        repeat (200) begin
            op = $urandom_range(0, 7);
            case (op)
                0: wr(1, 9'($urandom), 0, 0, 0, 0);
                1: wr(0, 0, 0, 1, 9'($urandom), 0);
                2: wr(1, 9'($urandom), 0, 1, 9'($urandom), 0);
                3: wr(1'($urandom_range(0, 1)), 9'($urandom), 1, 0, 0, 0);
                4: wr(0, 0, 0, 1'($urandom_range(0, 1)), 9'($urandom), 1);
                default: begin
                    b = 1'($urandom_range(0, 1));
                    len = b ? pbank.size() : mbank.size();
                    rd(b, 8'($urandom_range(0, len + 2)), 2);
                end
            endcase
        end
        chk("rand_drop", drop_count, expdrop());

        wr(0, 0, 0, 0, 0, 1);
        flood = 1;
        fork
            begin
                for (int i = 0; i < NFLOOD; i++) begin
                    main_ready = 1;
                    main_data = 9'(i + 1);
                    cyc();
                end
                main_ready = 0;
            end
            begin
                repeat (10) cyc();
                rd(0, 8'd0, SM + 3);
            end
        join
        repeat (6) cyc();
        flood = 0;
        drops += NFLOOD - MD;
        movf = 1;
        lastpriv = 0;
        for (int i = 0; i < MD; i++) mbank.push_back(9'h000);
        chk("flood_writes", fcnt, MD);
        chk("flood_main_len", main_len, MD);
        chk("flood_main_ovf", main_ovf, 1);
        chk("flood_drop", drop_count, expdrop());

        wr(0, 0, 0, 1, 9'h155, 1);

        rd_req = 1; rd_bank = 0; rd_offset = 0;
        cyc();
        chk("pre_rst_ram_re", ram_re, 1);
        reset = 1;
        cyc();
        rd_req = 0;
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_ram_re", ram_re, 0);
        chk("mid_rst_ram_we", ram_we, 0);
        chk("mid_rst_ram_addr", ram_addr, 0);
        chk("mid_rst_main_len", main_len, 0);
        chk("mid_rst_priv_len", priv_len, 0);
        chk("mid_rst_drop", drop_count, 0);
        reset = 0;
        model_reset();
        repeat (4) cyc();
        wr(1, 9'h0C5, 0, 1, 9'h1D5, 0);
        rd(0, 8'd0, 2);
        rd(1, 8'd0, 2);

        repeat (4) cyc();
        chk("rq_drained", rq.size(), 0);
        chk("wq_drained", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
